// File: rtl/csr_pkg.sv
// Shared definitions for the CSR instruction executor: funct3 encodings,
// FSM state encoding, the illegal-instruction cause code and the op decoder.
package csr_pkg;

    // CSR instruction funct3 encodings (bit 2 selects the immediate form)
    localparam logic [2:0] F3_RW  = 3'b001;
    localparam logic [2:0] F3_RS  = 3'b010;
    localparam logic [2:0] F3_RC  = 3'b011;
    localparam logic [2:0] F3_RWI = 3'b101;
    localparam logic [2:0] F3_RSI = 3'b110;
    localparam logic [2:0] F3_RCI = 3'b111;

    // Cause code reported with an illegal CSR access
    localparam logic [3:0] EXC_ILLEGAL = 4'd2;

    // Executor FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_e;

    // Read-modify-write operation class, independent of operand source
    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_SET   = 2'd2,
        OP_CLEAR = 2'd3
    } csr_op_e;

    // Map a funct3 encoding onto its operation class; reserved encodings
    // (000, 100) map to OP_NONE and are treated as illegal by the caller.
    function automatic csr_op_e decode_op(input logic [2:0] funct3);
        case (funct3)
            F3_RW, F3_RWI: return OP_WRITE;
            F3_RS, F3_RSI: return OP_SET;
            F3_RC, F3_RCI: return OP_CLEAR;
            default:       return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational new-value computation for CSR read-modify-write ops.
// Also reports whether the op actually performs a CSR write (set/clear with
// a zero rs1 index are read-only) and whether funct3 names a real op.
module csr_alu #(
    parameter int unsigned XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [4:0]      rs1_idx,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] old_val,
    output logic [XLEN-1:0] new_val,
    output logic            write_en,
    output logic            op_valid
);
    import csr_pkg::*;

    csr_op_e         op;
    logic [XLEN-1:0] source;

    // Select the operand (register or zero-extended zimm) and apply the op
    always_comb begin
        op       = decode_op(funct3);
        source   = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_data;
        new_val  = '0;
        write_en = 1'b0;
        op_valid = 1'b1;
        case (op)
            OP_WRITE: begin
                new_val  = source;
                write_en = 1'b1;
            end
            OP_SET: begin
                new_val  = old_val | source;
                write_en = (rs1_idx != 5'd0);
            end
            OP_CLEAR: begin
                new_val  = old_val & ~source;
                write_en = (rs1_idx != 5'd0);
            end
            default: begin
                op_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_exec.sv
// CSR instruction executor: accepts one CSR instruction from decode, reads
// the CSR file, optionally writes the new value back and presents the old
// value (or an illegal-instruction exception) to writeback.
// Optional feature: define CSR_RO_CHECK_EN to flag performed writes to the
// read-only CSR space (csr_addr[11:10] == 2'b11) locally.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | req_ready=1, waiting for an instruction
// ST_READ  | csr_addr driven, csr_rdata/csr_illegal sampled at cycle end
// ST_WRITE | single-cycle csr_we pulse with the computed new value
// ST_RESP  | result held on resp_* / rd_* / exc_* until resp_ready
module csr_exec #(
    parameter int unsigned XLEN        = 64,
    parameter logic [3:0]  EXC_ILLEGAL = csr_pkg::EXC_ILLEGAL
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      priv_lvl,
    input  logic [XLEN-1:0] pc,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_csr_addr,
    input  logic [4:0]      req_rs1_idx,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [4:0]      req_rd,
    output logic [11:0]     csr_addr,
    output logic            csr_we,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    input  logic            csr_illegal,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic            rd_we,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_wdata,
    output logic            exc_valid,
    output logic [XLEN-1:0] exc_pc,
    output logic [3:0]      exc_cause
);
    import csr_pkg::*;

    csr_state_e      state;

    // Instruction captured at acceptance
    logic [2:0]      f3_q;
    logic [11:0]     addr_q;
    logic [4:0]      idx_q;
    logic [XLEN-1:0] rs1_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] pc_q;
    logic [1:0]      priv_q;

    // Registered outputs
    logic            req_ready_q;
    logic            csr_we_q;
    logic [XLEN-1:0] csr_wdata_q;
    logic            resp_valid_q;
    logic            rd_we_q;
    logic [XLEN-1:0] rd_wdata_q;
    logic            exc_valid_q;
    logic [3:0]      exc_cause_q;

    logic [XLEN-1:0] alu_new;
    logic            alu_write;
    logic            alu_op_valid;
    logic            priv_fault;
    logic            ro_fault;
    logic            illegal_now;
    logic            do_write;

    csr_alu #(
        .XLEN(XLEN)
    ) u_alu (
        .funct3   (f3_q),
        .rs1_idx  (idx_q),
        .rs1_data (rs1_q),
        .old_val  (csr_rdata),
        .new_val  (alu_new),
        .write_en (alu_write),
        .op_valid (alu_op_valid)
    );

    // CSR address bits [9:8] give the lowest privilege allowed to touch it
    assign priv_fault = (addr_q[9:8] > priv_q);

`ifdef CSR_RO_CHECK_EN
    // Only a write that would really happen is a read-only violation
    assign ro_fault = alu_write & (addr_q[11:10] == 2'b11);
`else
    assign ro_fault = 1'b0;
`endif

    // Only meaningful in ST_READ, where csr_rdata/csr_illegal are valid
    assign illegal_now = csr_illegal | priv_fault | ~alu_op_valid | ro_fault;
    assign do_write    = alu_write & ~illegal_now;

    // Sequencer: capture, read, optional write, hold response
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            f3_q         <= '0;
            addr_q       <= '0;
            idx_q        <= '0;
            rs1_q        <= '0;
            rd_q         <= '0;
            pc_q         <= '0;
            priv_q       <= '0;
            req_ready_q  <= 1'b0;
            csr_we_q     <= 1'b0;
            csr_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            rd_we_q      <= 1'b0;
            rd_wdata_q   <= '0;
            exc_valid_q  <= 1'b0;
            exc_cause_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    csr_we_q    <= 1'b0;
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        f3_q        <= req_funct3;
                        addr_q      <= req_csr_addr;
                        idx_q       <= req_rs1_idx;
                        rs1_q       <= req_rs1_data;
                        rd_q        <= req_rd;
                        pc_q        <= pc;
                        priv_q      <= priv_lvl;
                        req_ready_q <= 1'b0;
                        state       <= ST_READ;
                    end
                end
                ST_READ: begin
                    rd_wdata_q  <= csr_rdata;
                    rd_we_q     <= ~illegal_now & (rd_q != 5'd0);
                    exc_valid_q <= illegal_now;
                    exc_cause_q <= illegal_now ? EXC_ILLEGAL : 4'd0;
                    if (do_write) begin
                        csr_we_q    <= 1'b1;
                        csr_wdata_q <= alu_new;
                        state       <= ST_WRITE;
                    end else begin
                        resp_valid_q <= 1'b1;
                        state        <= ST_RESP;
                    end
                end
                ST_WRITE: begin
                    csr_we_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state        <= ST_RESP;
                end
                ST_RESP: begin
                    csr_we_q <= 1'b0;
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    csr_we_q     <= 1'b0;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign csr_addr   = addr_q;
    assign csr_we     = csr_we_q;
    assign csr_wdata  = csr_wdata_q;
    assign resp_valid = resp_valid_q;
    assign rd_we      = rd_we_q;
    assign rd_addr    = rd_q;
    assign rd_wdata   = rd_wdata_q;
    assign exc_valid  = exc_valid_q;
    assign exc_pc     = pc_q;
    assign exc_cause  = exc_cause_q;

endmodule

// File: tb/tb_csr_exec.sv
// Self-checking bench for csr_exec: directed cases plus randomized
// instructions, compared every cycle against a transaction-level model.
module tb_csr_exec;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [1:0]      priv_lvl = '0;
    logic [XLEN-1:0] pc = '0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [2:0]      req_funct3 = '0;
    logic [11:0]     req_csr_addr = '0;
    logic [4:0]      req_rs1_idx = '0;
    logic [XLEN-1:0] req_rs1_data = '0;
    logic [4:0]      req_rd = '0;
    logic [11:0]     csr_addr;
    logic            csr_we;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_illegal;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic            rd_we;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic            exc_valid;
    logic [XLEN-1:0] exc_pc;
    logic [3:0]      exc_cause;

    always #5 clk = ~clk;

    csr_exec #(.XLEN(XLEN), .EXC_ILLEGAL(4'd2)) dut (
        .clk(clk), .reset(reset), .priv_lvl(priv_lvl), .pc(pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
        .req_csr_addr(req_csr_addr), .req_rs1_idx(req_rs1_idx),
        .req_rs1_data(req_rs1_data), .req_rd(req_rd),
        .csr_addr(csr_addr), .csr_we(csr_we), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_wdata(rd_wdata),
        .exc_valid(exc_valid), .exc_pc(exc_pc), .exc_cause(exc_cause)
    );

    // CSR file stand-in: returns the prepared value only at the right address
    logic [11:0]     file_addr = '0;
    logic [XLEN-1:0] file_rdata = '0;
    logic            file_ill = 1'b0;
    assign csr_rdata   = (csr_addr == file_addr) ? file_rdata : ~file_rdata;
    assign csr_illegal = (csr_addr == file_addr) ? file_ill : 1'b1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model expectations for the instruction in flight
    logic            exp_wr;
    logic [XLEN-1:0] exp_wdata;
    logic            exp_rd_we;
    logic [4:0]      exp_rd_addr;
    logic [XLEN-1:0] exp_rd_wdata;
    logic            exp_exc;
    logic [XLEN-1:0] exp_pc;
    logic [11:0]     exp_addr;
    int              exp_lat;

    task automatic model(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                         input logic [XLEN-1:0] rs1, input logic [4:0] rd, input logic [XLEN-1:0] pcv,
                         input logic [1:0] priv, input logic [XLEN-1:0] old, input logic ill_in);
        logic [XLEN-1:0] src;
        logic [XLEN-1:0] nv;
        logic            wr;
        logic            bad;
        logic            ill;
        src = rs1;
        if (f3 >= 3'd5) src = {{(XLEN-5){1'b0}}, idx};
        nv  = '0;
        wr  = 1'b0;
        bad = 1'b0;
        case (f3)
            3'b001, 3'b101: begin nv = src;        wr = 1'b1;         end
            3'b010, 3'b110: begin nv = old | src;  wr = (idx != 0);   end
            3'b011, 3'b111: begin nv = old & ~src; wr = (idx != 0);   end
            default:        bad = 1'b1;
        endcase
        ill = ill_in || (int'(addr[9:8]) > int'(priv)) || bad;
`ifdef CSR_RO_CHECK_EN
        if (wr && addr[11:10] == 2'b11) ill = 1'b1;
`endif
        exp_wr       = wr && !ill;
        exp_wdata    = nv;
        exp_lat      = exp_wr ? 3 : 2;
        exp_rd_we    = !ill && (rd != 0);
        exp_rd_addr  = rd;
        exp_rd_wdata = old;
        exp_exc      = ill;
        exp_pc       = pcv;
        exp_addr     = addr;
    endtask

    bit              started = 1'b0;
    bit              active = 1'b0;
    int              cyc = 0;
    int              since_rst = 0;
    int              acc_cyc = 0;
    int              since;
    int              we_count = 0;
    logic [XLEN-1:0] last_wdata = '0;

    // Cycle bookkeeping only; no DUT outputs are read here
    always @(posedge clk) begin
        started = 1'b1;
        cyc++;
        since_rst = reset ? since_rst + 1 : 0;
    end

    // Single compare process, sampling mid-cycle
    always @(negedge clk) begin
        if (started) begin
            if (since_rst == 0) begin
                check("rst_req_ready", 64'(req_ready), 64'd0);
                check("rst_ctl_zero", 64'({csr_we, resp_valid, rd_we, exc_valid}), 64'd0);
                check("rst_addr_zero", 64'({csr_addr, rd_addr, exc_cause}), 64'd0);
                check("rst_csr_wdata", csr_wdata, 64'd0);
                check("rst_rd_wdata", rd_wdata, 64'd0);
                check("rst_exc_pc", exc_pc, 64'd0);
            end else begin
                if (csr_we) begin
                    we_count++;
                    last_wdata = csr_wdata;
                end
                if (active) begin
                    since = cyc - acc_cyc + 1;
                    check("busy_req_ready", 64'(req_ready), 64'd0);
                    check("csr_addr", 64'(csr_addr), 64'(exp_addr));
                    check("csr_we", 64'(csr_we), 64'(exp_wr && since == 2));
                    if (exp_wr && since == 2) check("csr_wdata", csr_wdata, exp_wdata);
                    check("resp_valid", 64'(resp_valid), 64'(since >= exp_lat));
                    if (since >= exp_lat) begin
                        check("rd_we", 64'(rd_we), 64'(exp_rd_we));
                        check("rd_addr", 64'(rd_addr), 64'(exp_rd_addr));
                        check("rd_wdata", rd_wdata, exp_rd_wdata);
                        check("exc_valid", 64'(exc_valid), 64'(exp_exc));
                        check("exc_pc", exc_pc, exp_pc);
                        check("exc_cause", 64'(exc_cause), exp_exc ? 64'd2 : 64'd0);
                    end
                end else begin
                    check("idle_req_ready", 64'(req_ready), 64'd1);
                    check("idle_resp_valid", 64'(resp_valid), 64'd0);
                    check("idle_csr_we", 64'(csr_we), 64'd0);
                end
            end
        end
    end

    int lat_seen;

    task automatic run_txn(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] idx,
                           input logic [XLEN-1:0] rs1, input logic [4:0] rd, input logic [XLEN-1:0] pcv,
                           input logic [1:0] priv, input logic [XLEN-1:0] old, input logic ill_in,
                           input int stall, input bit rst_in_resp);
        @(posedge clk); #1;
        req_valid    = 1'b1;
        req_funct3   = f3;
        req_csr_addr = addr;
        req_rs1_idx  = idx;
        req_rs1_data = rs1;
        req_rd       = rd;
        pc           = pcv;
        priv_lvl     = priv;
        file_addr    = addr;
        file_rdata   = old;
        file_ill     = ill_in;
        model(f3, addr, idx, rs1, rd, pcv, priv, old, ill_in);
        @(posedge clk); #1;
        active       = 1'b1;
        acc_cyc      = cyc;
        req_valid    = 1'b0;
        req_funct3   = 3'($urandom);
        req_csr_addr = 12'($urandom);
        req_rs1_idx  = 5'($urandom);
        req_rs1_data = {$urandom, $urandom};
        req_rd       = 5'($urandom);
        pc           = {$urandom, $urandom};
        priv_lvl     = 2'($urandom);
        lat_seen     = 0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) begin
                file_rdata = {$urandom, $urandom};
                file_ill   = 1'($urandom);
            end
            if (resp_valid) begin
                lat_seen = i;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat_seen == 0) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 8 cycles");
            reset = 1'b0;
            @(posedge clk); #1;
            active = 1'b0;
            reset  = 1'b1;
            return;
        end
        check("latency", 64'(lat_seen), 64'(exp_lat));
        repeat (stall) begin
            @(posedge clk); #1;
        end
        if (rst_in_resp) begin
            reset = 1'b0;
            @(posedge clk); #1;
            active = 1'b0;
            reset  = 1'b1;
        end else begin
            resp_ready = 1'b1;
            @(posedge clk); #1;
            resp_ready = 1'b0;
            active     = 1'b0;
        end
    endtask

    int we0;

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // CSRRW at M, write 0xA5, old 0x11
        we0 = we_count;
        run_txn(3'b001, 12'h340, 5'd10, 64'hA5, 5'd5, 64'h8000_1000, 2'd3, 64'h11, 1'b0, 0, 1'b0);
        check("pin_rw_wdata", exp_wdata, 64'hA5);
        check("pin_rw_rd_wdata", exp_rd_wdata, 64'h11);
        check("pin_rw_rd_we", 64'(exp_rd_we), 64'd1);
        check("pin_rw_lat", 64'(lat_seen), 64'd3);
        check("pin_rw_we_count", 64'(we_count - we0), 64'd1);
        check("pin_rw_last_wdata", last_wdata, 64'hA5);

        // CSRRS with rs1_idx=0: read only
        we0 = we_count;
        run_txn(3'b010, 12'h300, 5'd0, 64'hFFFF, 5'd7, 64'h8000_1004, 2'd3, 64'h1234, 1'b0, 1, 1'b0);
        check("pin_rs0_lat", 64'(lat_seen), 64'd2);
        check("pin_rs0_we_count", 64'(we_count - we0), 64'd0);

        // CSRRCI zimm=3 on 0xF
        we0 = we_count;
        run_txn(3'b111, 12'h340, 5'd3, 64'h0, 5'd1, 64'h8000_1008, 2'd3, 64'hF, 1'b0, 0, 1'b0);
        check("pin_rci_wdata", exp_wdata, 64'hC);
        check("pin_rci_last_wdata", last_wdata, 64'hC);
        check("pin_rci_we_count", 64'(we_count - we0), 64'd1);

        // U-mode write to an M-mode CSR
        we0 = we_count;
        run_txn(3'b001, 12'h300, 5'd4, 64'h55, 5'd9, 64'h8000_100C, 2'd0, 64'h77, 1'b0, 0, 1'b0);
        check("pin_priv_exc", 64'(exp_exc), 64'd1);
        check("pin_priv_rd_we", 64'(exp_rd_we), 64'd0);
        check("pin_priv_we_count", 64'(we_count - we0), 64'd0);
        check("pin_priv_lat", 64'(lat_seen), 64'd2);

        // Stall 4 cycles in RESP, then reset
        run_txn(3'b001, 12'h341, 5'd2, 64'h99, 5'd3, 64'h8000_1010, 2'd3, 64'h42, 1'b0, 4, 1'b1);
        @(posedge clk); #1;
        check("pin_post_rst_ready", 64'(req_ready), 64'd1);

        // Write to the read-only space
        we0 = we_count;
        run_txn(3'b001, 12'hC00, 5'd6, 64'h1, 5'd2, 64'h8000_1014, 2'd3, 64'h5, 1'b0, 0, 1'b0);
`ifdef CSR_RO_CHECK_EN
        check("pin_ro_exc", 64'(exp_exc), 64'd1);
        check("pin_ro_we_count", 64'(we_count - we0), 64'd0);
`else
        check("pin_ro_exc", 64'(exp_exc), 64'd0);
        check("pin_ro_we_count", 64'(we_count - we0), 64'd1);
`endif

        // Randomized instructions
        for (int n = 0; n < 250; n++) begin
            logic [1:0] pr;
            logic [4:0] idx;
            logic [4:0] rd;
            pr  = 2'($urandom_range(0, 2));
            if (pr == 2'd2) pr = 2'd3;
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd  = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
            run_txn(3'($urandom), 12'($urandom), idx, {$urandom, $urandom}, rd,
                    {$urandom, $urandom}, pr, {$urandom, $urandom},
                    1'($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                    ($urandom_range(0, 24) == 0));
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
